dtw_channel_scheduler: RTL and testbench

//  Shares one dtw engine between N_CH pose-joint channels, round-robin.
//  Per job: grant one channel, start the engine, and stream that channel's reference and

---
 rtl/dtw_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 33 +++
 rtl/dtw_channel_scheduler.sv | 182 ++++++++++++++++++
 tb/tb_dtw_channel_scheduler.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dtw_pkg.sv
// Shared types and helpers for the dtw channel scheduler and its arbiter.
package dtw_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } sched_state_t;

    // All-ones value of the given width, returned zero-extended to 64 bits.
    function automatic logic [63:0] score_max(input int width);
        logic [63:0] val;
        if (width >= 64) begin
            val = '1;
        end else begin
            val = (64'd1 << width) - 64'd1;
        end
        return val;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins,
// searching upward and wrapping to 0.
module rr_arbiter #(
    parameter int N = 4,
    localparam int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] grant,
    output logic [W-1:0] idx,
    output logic         any
);

    always_comb begin
        int j;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        for (int i = 0; i < N; i++) begin
            j = int'(ptr) + i;
            if (j >= N) begin
                j = j - N;
            end
            if (!any && req[W'(j)]) begin
                any          = 1'b1;
                grant[W'(j)] = 1'b1;
                idx          = W'(j);
            end
        end
    end

endmodule

// File: rtl/dtw_channel_scheduler.sv
// Time-shares one dtw engine across N_CH channels: round-robin grant, sample
// streaming from the reference/camera RAMs, watchdog abort and tagged result.
module dtw_channel_scheduler
    import dtw_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int DATA_WIDTH = 10,
    parameter int SIZE       = 20,
    parameter int TIMEOUT    = 4096,
    localparam int AW = $clog2(N_CH * SIZE),
    localparam int CW = $clog2(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_CH-1:0]       ch_req,
    output logic [N_CH-1:0]       ch_ack,
    output logic [AW-1:0]         ref_addr,
    input  logic [DATA_WIDTH-1:0] ref_rdata,
    output logic [AW-1:0]         cam_addr,
    input  logic [DATA_WIDTH-1:0] cam_rdata,
    output logic                  eng_ready,
    output logic [DATA_WIDTH-1:0] eng_refer,
    output logic [DATA_WIDTH-1:0] eng_camera,
    input  logic                  eng_ready_refer,
    input  logic                  eng_ready_camera,
    input  logic                  eng_done,
    input  logic [DATA_WIDTH-1:0] eng_score,
    output logic                  res_valid,
    output logic [CW-1:0]         res_ch,
    output logic [DATA_WIDTH-1:0] res_score,
    output logic                  res_err,
    output logic                  busy
);

    localparam int IW = $clog2(SIZE);
    localparam int WW = $clog2(TIMEOUT);
    localparam logic [IW-1:0]         IDX_LAST      = IW'(SIZE - 1);
    localparam logic [WW-1:0]         WDOG_LAST     = WW'(TIMEOUT - 1);
    localparam logic [AW-1:0]         SIZE_A        = AW'(SIZE);
    localparam logic [CW-1:0]         CH_LAST       = CW'(N_CH - 1);
    localparam logic [DATA_WIDTH-1:0] SCORE_TIMEOUT = DATA_WIDTH'(score_max(DATA_WIDTH));

    sched_state_t          state_reg, state_next;
    logic [CW-1:0]         cur_reg, cur_next;
    logic [N_CH-1:0]       cur_oh_reg, cur_oh_next;
    logic [CW-1:0]         rr_ptr_reg, rr_ptr_next;
    logic [IW-1:0]         ref_idx_reg, ref_idx_next;
    logic [IW-1:0]         cam_idx_reg, cam_idx_next;
    logic [WW-1:0]         wdog_reg, wdog_next;
    logic [AW-1:0]         ref_addr_reg, ref_addr_next;
    logic [AW-1:0]         cam_addr_reg, cam_addr_next;
    logic [DATA_WIDTH-1:0] res_score_reg, res_score_next;
    logic                  res_err_reg, res_err_next;

    logic [N_CH-1:0] arb_grant;
    logic [CW-1:0]   arb_idx;
    logic            arb_any;
    logic            in_run, svc_ref, svc_cam;
    logic [AW-1:0]   ref_addr_now, cam_addr_now;

    rr_arbiter #(.N(N_CH)) u_arb (
        .req   (ch_req),
        .ptr   (rr_ptr_reg),
        .grant (arb_grant),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    assign in_run       = (state_reg == RUN);
    assign svc_ref      = in_run & eng_ready_refer;
    assign svc_cam      = in_run & eng_ready_camera;
    assign ref_addr_now = AW'(cur_reg) * SIZE_A + AW'(ref_idx_reg);
    assign cam_addr_now = AW'(cur_reg) * SIZE_A + AW'(cam_idx_reg);

    // The RAM keeps re-reading the last requested address, so its output
    // doubles as the held sample until the engine asks for the next one.
    assign ref_addr   = svc_ref ? ref_addr_now : ref_addr_reg;
    assign cam_addr   = svc_cam ? cam_addr_now : cam_addr_reg;
    assign eng_refer  = ref_rdata;
    assign eng_camera = cam_rdata;

    assign eng_ready = in_run;
    assign busy      = (state_reg != IDLE);
    assign res_valid = (state_reg == DRAIN);
    assign ch_ack    = res_valid ? cur_oh_reg : '0;
    assign res_ch    = cur_reg;
    assign res_score = res_score_reg;
    assign res_err   = res_err_reg;

    always_comb begin
        state_next     = state_reg;
        cur_next       = cur_reg;
        cur_oh_next    = cur_oh_reg;
        rr_ptr_next    = rr_ptr_reg;
        ref_idx_next   = ref_idx_reg;
        cam_idx_next   = cam_idx_reg;
        wdog_next      = wdog_reg;
        ref_addr_next  = ref_addr_reg;
        cam_addr_next  = cam_addr_reg;
        res_score_next = res_score_reg;
        res_err_next   = res_err_reg;

        case (state_reg)
            IDLE: begin
                if (|ch_req) begin
                    state_next = GRANT;
                end
            end
            GRANT: begin
                // A request withdrawn before the grant simply returns to IDLE.
                if (arb_any) begin
                    cur_next     = arb_idx;
                    cur_oh_next  = arb_grant;
                    ref_idx_next = '0;
                    cam_idx_next = '0;
                    wdog_next    = '0;
                    state_next   = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            RUN: begin
                wdog_next = wdog_reg + 1'b1;
                if (svc_ref) begin
                    ref_addr_next = ref_addr_now;
                    if (ref_idx_reg != IDX_LAST) begin
                        ref_idx_next = ref_idx_reg + 1'b1;
                    end
                end
                if (svc_cam) begin
                    cam_addr_next = cam_addr_now;
                    if (cam_idx_reg != IDX_LAST) begin
                        cam_idx_next = cam_idx_reg + 1'b1;
                    end
                end
                if (eng_done) begin
                    res_score_next = eng_score;
                    res_err_next   = 1'b0;
                    state_next     = DRAIN;
                end else if (wdog_reg == WDOG_LAST) begin
                    res_score_next = SCORE_TIMEOUT;
                    res_err_next   = 1'b1;
                    state_next     = DRAIN;
                end
            end
            DRAIN: begin
                rr_ptr_next = (cur_reg == CH_LAST) ? '0 : cur_reg + 1'b1;
                state_next  = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            cur_reg       <= '0;
            cur_oh_reg    <= '0;
            rr_ptr_reg    <= '0;
            ref_idx_reg   <= '0;
            cam_idx_reg   <= '0;
            wdog_reg      <= '0;
            ref_addr_reg  <= '0;
            cam_addr_reg  <= '0;
            res_score_reg <= '0;
            res_err_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cur_reg       <= cur_next;
            cur_oh_reg    <= cur_oh_next;
            rr_ptr_reg    <= rr_ptr_next;
            ref_idx_reg   <= ref_idx_next;
            cam_idx_reg   <= cam_idx_next;
            wdog_reg      <= wdog_next;
            ref_addr_reg  <= ref_addr_next;
            cam_addr_reg  <= cam_addr_next;
            res_score_reg <= res_score_next;
            res_err_reg   <= res_err_next;
        end
    end

endmodule

// File: tb/tb_dtw_channel_scheduler.sv
// Scoreboard bench for dtw_channel_scheduler: an engine BFM drives ready/done
// timing, behavioural RAMs supply samples, a monitor checks results and samples.
module tb_dtw_channel_scheduler;

    localparam int N_CH    = 4;
    localparam int DW      = 10;
    localparam int SIZE    = 20;
    localparam int TIMEOUT = 64;
    localparam int AW      = $clog2(N_CH * SIZE);
    localparam int CW      = $clog2(N_CH);

    logic            clk = 1'b0;
    logic            rst;
    logic [N_CH-1:0] ch_req;
    logic [N_CH-1:0] ch_ack;
    logic [AW-1:0]   ref_addr, cam_addr;
    logic [DW-1:0]   ref_rdata, cam_rdata;
    logic            eng_ready;
    logic [DW-1:0]   eng_refer, eng_camera;
    logic            eng_ready_refer, eng_ready_camera;
    logic            eng_done;
    logic [DW-1:0]   eng_score;
    logic            res_valid;
    logic [CW-1:0]   res_ch;
    logic [DW-1:0]   res_score;
    logic            res_err;
    logic            busy;

    dtw_channel_scheduler #(
        .N_CH(N_CH), .DATA_WIDTH(DW), .SIZE(SIZE), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .ch_req(ch_req), .ch_ack(ch_ack),
        .ref_addr(ref_addr), .ref_rdata(ref_rdata),
        .cam_addr(cam_addr), .cam_rdata(cam_rdata),
        .eng_ready(eng_ready), .eng_refer(eng_refer), .eng_camera(eng_camera),
        .eng_ready_refer(eng_ready_refer), .eng_ready_camera(eng_ready_camera),
        .eng_done(eng_done), .eng_score(eng_score),
        .res_valid(res_valid), .res_ch(res_ch), .res_score(res_score),
        .res_err(res_err), .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural sync RAMs: ref[a] = 80 + a (channel 1 holds 100..119), cam[a] = 600 - a.
    logic [DW-1:0] ref_mem [N_CH*SIZE];
    logic [DW-1:0] cam_mem [N_CH*SIZE];
    always @(posedge clk) begin
        ref_rdata <= ref_mem[ref_addr];
        cam_rdata <= cam_mem[cam_addr];
    end

    typedef struct {
        int            ch;
        logic [DW-1:0] score;
        logic          err;
    } exp_t;

    exp_t exp_q [$];
    int   ref_q [$];
    int   cam_q [$];
    int   ack_t [$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   cyc     = 0;
    logic ref_pend = 1'b0;
    logic cam_pend = 1'b0;
    exp_t mon_e;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        ref_pend <= eng_ready_refer;
        cam_pend <= eng_ready_camera;
    end

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic int sample_addr(input int ch, input int k);
        return ch * SIZE + ((k > SIZE - 1) ? SIZE - 1 : k);
    endfunction

    // Monitor: pops the scoreboard on every result/ack and on every sample delivery.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && (res_valid || ch_ack != '0)) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_result: ch=%0d ack=%b valid=%0b, expected no result",
                             res_ch, ch_ack, res_valid);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("res_valid", int'(res_valid), 1);
                    check("res_ch", int'(res_ch), mon_e.ch);
                    check("res_score", int'(res_score), int'(mon_e.score));
                    check("res_err", int'(res_err), int'(mon_e.err));
                    check("ch_ack", int'(ch_ack), 1 << mon_e.ch);
                    ack_t.push_back(cyc);
                end
            end
            if (ref_pend) begin
                if (ref_q.size() == 0) begin
                    n_total++;
                    $display("FAIL ref_unexpected: got %0d, expected no request", eng_refer);
                end else begin
                    check("ref_sample", int'(eng_refer), ref_q.pop_front());
                end
            end
            if (cam_pend) begin
                if (cam_q.size() == 0) begin
                    n_total++;
                    $display("FAIL cam_unexpected: got %0d, expected no request", eng_camera);
                end else begin
                    check("cam_sample", int'(eng_camera), cam_q.pop_front());
                end
            end
        end
    end

    // Engine BFM: waits for eng_ready, requests n_ref/n_cam samples from RUN cycle 0,
    // pulses done at RUN cycle done_at (never when negative). Returns at the DRAIN cycle.
    task automatic bfm_job(input int ch, input int n_ref, input int n_cam, input int done_at,
                           input logic [DW-1:0] score, input bit hold, output int run_len);
        int c;
        int guard;
        exp_t e;
        guard   = 0;
        run_len = 0;
        while (!eng_ready && guard < 60) begin
            @(negedge clk);
            guard++;
        end
        if (!eng_ready) begin
            check("bfm_start_timeout", 0, 1);
            return;
        end
        e.ch    = ch;
        e.score = (done_at >= 0) ? score : 10'h3FF;
        e.err   = (done_at >= 0) ? 1'b0 : 1'b1;
        exp_q.push_back(e);
        c = 0;
        while (eng_ready && c < 200) begin
            eng_ready_refer  = (c < n_ref);
            eng_ready_camera = (c < n_cam);
            if (c < n_ref) ref_q.push_back(80 + sample_addr(ch, c));
            if (c < n_cam) cam_q.push_back(600 - sample_addr(ch, c));
            eng_done  = (c == done_at);
            eng_score = score;
            @(negedge clk);
            c++;
        end
        eng_ready_refer  = 1'b0;
        eng_ready_camera = 1'b0;
        eng_done         = 1'b0;
        run_len          = c;
        if (!hold) ch_req = ch_req & ~(4'b0001 << ch);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running, expected completion");
        $fatal(1);
    end

    initial begin
        int rl;
        int g;
        for (int a = 0; a < N_CH * SIZE; a++) begin
            ref_mem[a] = DW'(80 + a);
            cam_mem[a] = DW'(600 - a);
        end
        rst = 1'b1; ch_req = '0; eng_ready_refer = 1'b0; eng_ready_camera = 1'b0;
        eng_done = 1'b0; eng_score = '0;
        repeat (3) @(negedge clk);

        $display("reset state check");
        check("rst_eng_ready", int'(eng_ready), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_res_valid", int'(res_valid), 0);
        check("rst_ch_ack", int'(ch_ack), 0);
        check("rst_ref_addr", int'(ref_addr), 0);
        check("rst_cam_addr", int'(cam_addr), 0);
        check("rst_res_score", int'(res_score), 0);
        check("rst_res_err", int'(res_err), 0);
        rst = 1'b0;
        @(negedge clk);

        eng_done = 1'b1; eng_score = 10'd99;
        @(negedge clk);
        eng_done = 1'b0;
        @(negedge clk);
        check("done_in_idle_busy", int'(busy), 0);
        $display("txn: stray eng_done in IDLE");

        // Single requester, done at RUN cycle 60 with score 37.
        ch_req = 4'b0100;
        bfm_job(2, 3, 5, 60, 10'd37, 1'b0, rl);
        check("t1_run_len", rl, 61);
        $display("txn: ch2 done score 37, run_len=%0d", rl);
        repeat (3) @(negedge clk);

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // All four held: grant order 0,1,2,3,0 with a fixed job period of done_at+4.
        ack_t.delete();
        ch_req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            bfm_job(i % 4, 2, 1, 3, DW'(10 + i), 1'b1, rl);
            $display("txn: rr job %0d for ch%0d", i, i % 4);
        end
        ch_req = '0;
        repeat (3) @(negedge clk);
        check("t2_ack_count", ack_t.size(), 5);
        for (int i = 1; i < 5 && i < ack_t.size(); i++) begin
            check("t2_ack_interval", ack_t[i] - ack_t[i-1], 7);
        end

        // Channel 1 reference stream, 21 requests (last re-reads sample 19).
        ch_req = 4'b0010;
        bfm_job(1, 21, 0, 25, 10'd5, 1'b0, rl);
        $display("txn: ch1 ref stream 21 requests");
        repeat (3) @(negedge clk);

        // Watchdog: no done; result appears 64 cycles after eng_ready rises.
        ch_req = 4'b1000;
        bfm_job(3, 2, 0, -1, '0, 1'b0, rl);
        check("t4_timeout_latency", rl, 64);
        check("t4_res_valid_at_latency", int'(res_valid), 1);
        $display("txn: ch3 timeout after %0d cycles", rl);
        repeat (3) @(negedge clk);

        // Simultaneous ref/cam requests every cycle.
        ch_req = 4'b0100;
        bfm_job(2, 21, 21, 30, 10'd200, 1'b0, rl);
        $display("txn: ch2 dual stream score 200");
        repeat (3) @(negedge clk);

        // Reset mid-RUN, then the next grant must start from pointer 0.
        ch_req = 4'b0001;
        g = 0;
        while (!eng_ready && g < 60) begin
            @(negedge clk);
            g++;
        end
        check("t6_job_started", int'(eng_ready), 1);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        check("t6_eng_ready", int'(eng_ready), 0);
        check("t6_busy", int'(busy), 0);
        check("t6_ch_ack", int'(ch_ack), 0);
        check("t6_res_valid", int'(res_valid), 0);
        $display("txn: reset mid-RUN");
        @(negedge clk);
        ch_req = '0;
        rst = 1'b0;
        @(negedge clk);
        ch_req = 4'b1010;
        bfm_job(1, 1, 1, 4, 10'd77, 1'b1, rl);
        ch_req = '0;
        $display("txn: post-reset grant ch1");
        repeat (5) @(negedge clk);

        check("sb_results_drained", exp_q.size(), 0);
        check("sb_ref_drained", ref_q.size(), 0);
        check("sb_cam_drained", cam_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
